// File: rtl/filter_mode_ctrl.sv
// Filter-chain mode controller: debounced buttons / direct switches -> filter enables.
// Optional macro FRAME_SYNC_EN: commit enables only on a vsync rising edge.
module filter_mode_ctrl #(
    parameter int  NUM_FILTERS     = 8,
    parameter int  DEBOUNCE_CYCLES = 50000,
    localparam int IW              = $clog2(NUM_FILTERS + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   btn_next,
    input  logic                   btn_prev,
    input  logic                   sw_mode,
    input  logic [NUM_FILTERS-1:0] sw_direct,
    input  logic                   vsync,
    output logic [NUM_FILTERS-1:0] en_out,
    output logic [IW-1:0]          mode_idx,
    output logic                   pending
);

    localparam logic [15:0] DB_LAST = 16'(DEBOUNCE_CYCLES - 1);
    localparam logic [IW-1:0] MODE_MAX = IW'(NUM_FILTERS);

    function automatic logic [NUM_FILTERS-1:0] one_hot(input logic [IW-1:0] idx);
        logic [NUM_FILTERS-1:0] v;
        v = '0;
        for (int k = 0; k < NUM_FILTERS; k++) begin
            if (idx == IW'(k + 1)) v[k] = 1'b1;
        end
        return v;
    endfunction

    // Synchronisers are left unreset so a button held through reset stays visible as held.
    logic [1:0]             btn_s1, btn_s2;
    logic                   sw_mode_s1, sw_mode_s2;
    logic [NUM_FILTERS-1:0] sw_direct_s1, sw_direct_s2;

    always_ff @(posedge clk) begin
        btn_s1       <= {btn_prev, btn_next};
        btn_s2       <= btn_s1;
        sw_mode_s1   <= sw_mode;
        sw_mode_s2   <= sw_mode_s1;
        sw_direct_s1 <= sw_direct;
        sw_direct_s2 <= sw_direct_s1;
    end

    // Index 0 = next, 1 = prev. A button must be seen released after reset before
    // it can produce a press, so a key held through reset is ignored.
    logic [1:0][15:0] db_cnt;
    logic [1:0]       stable;
    logic [1:0]       armed;
    logic [1:0]       press;

    always_ff @(posedge clk) begin
        if (rst) begin
            db_cnt <= '0;
            stable <= '0;
            armed  <= '0;
            press  <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                press[i] <= 1'b0;
                if (!btn_s2[i]) armed[i] <= 1'b1;
                if (btn_s2[i] == stable[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    stable[i] <= btn_s2[i];
                    db_cnt[i] <= '0;
                    press[i]  <= btn_s2[i] & armed[i];
                end else begin
                    db_cnt[i] <= db_cnt[i] + 16'd1;
                end
            end
        end
    end

    logic [IW-1:0] mode_nxt;

    always_comb begin
        mode_nxt = mode_idx;
        if (!sw_mode_s2 && (press[0] ^ press[1])) begin
            if (press[0]) mode_nxt = (mode_idx == MODE_MAX) ? '0 : mode_idx + IW'(1);
            else          mode_nxt = (mode_idx == '0) ? MODE_MAX : mode_idx - IW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) mode_idx <= '0;
        else     mode_idx <= mode_nxt;
    end

    logic [NUM_FILTERS-1:0] target;
    assign target = sw_mode_s2 ? sw_direct_s2 : one_hot(mode_idx);

`ifdef FRAME_SYNC_EN
    // state   | meaning
    // IDLE    | en_out matches target
    // PENDING | target differs from en_out, waiting for a vsync rising edge
    typedef enum logic {IDLE, PENDING} state_t;
    state_t state;

    logic vsync_s1, vsync_s2, vsync_d;
    logic vs_rise;

    always_ff @(posedge clk) begin
        vsync_s1 <= vsync;
        vsync_s2 <= vsync_s1;
        vsync_d  <= vsync_s2;
    end

    assign vs_rise = vsync_s2 & ~vsync_d;

    // target as it will be after this edge, so a change landing on the commit
    // cycle keeps the FSM pending for the next frame.
    logic [NUM_FILTERS-1:0] target_nxt;
    assign target_nxt = sw_mode_s1 ? sw_direct_s1 : one_hot(mode_nxt);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            en_out  <= '0;
            pending <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (target != en_out) begin
                        state   <= PENDING;
                        pending <= 1'b1;
                    end
                end
                PENDING: begin
                    if (vs_rise) begin
                        en_out <= target;
                        if (target_nxt == target) begin
                            state   <= IDLE;
                            pending <= 1'b0;
                        end
                    end else if (target == en_out) begin
                        state   <= IDLE;
                        pending <= 1'b0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    pending <= 1'b0;
                end
            endcase
        end
    end
`else
    logic unused_vsync;
    assign unused_vsync = vsync;
    assign pending      = 1'b0;

    always_ff @(posedge clk) begin
        if (rst) en_out <= '0;
        else     en_out <= target;
    end
`endif

endmodule

// File: tb/tb_filter_mode_ctrl.sv
// Bench for filter_mode_ctrl: directed scenarios plus random stimulus against a
// cycle-level behavioural model; works with or without FRAME_SYNC_EN.
module tb_filter_mode_ctrl;

    localparam int NF = 8;
    localparam int DB = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          btn_next, btn_prev, sw_mode, vsync;
    logic [NF-1:0] sw_direct;
    logic [NF-1:0] en_out;
    logic [3:0]    mode_idx;
    logic          pending;

    filter_mode_ctrl #(.NUM_FILTERS(NF), .DEBOUNCE_CYCLES(DB)) dut (
        .clk(clk), .rst(rst), .btn_next(btn_next), .btn_prev(btn_prev),
        .sw_mode(sw_mode), .sw_direct(sw_direct), .vsync(vsync),
        .en_out(en_out), .mode_idx(mode_idx), .pending(pending)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    typedef struct packed {
        logic          bn;
        logic          bp;
        logic          sm;
        logic [NF-1:0] sd;
        logic          vs;
    } raw_t;

    raw_t       hist [2];
    int         m_mode = 0;
    logic [7:0] m_en = '0;
    bit         m_pend = 0;
    bit         m_valid = 0;
    bit         m_vs_d = 0;
    bit         st [2];
    int         run [2];
    bit         arm [2];
    bit         pls [2];

    function automatic logic [7:0] tgt(input int mode, input logic sm, input logic [7:0] sd);
        if (sm) return sd;
        if (mode == 0) return 8'h00;
        return 8'(1 << (mode - 1));
    endfunction

    task automatic model_step();
        raw_t       cur, nxt, now;
        logic [7:0] tgt_now, tgt_aft;
        bit         vs_rise;
        bit         lvl [2];
        cur = hist[1];
        nxt = hist[0];
        now = '{bn: btn_next, bp: btn_prev, sm: sw_mode, sd: sw_direct, vs: vsync};
        if (rst) begin
            m_mode = 0; m_en = '0; m_pend = 0; m_valid = 1;
            for (int i = 0; i < 2; i++) begin
                st[i] = 0; run[i] = 0; arm[i] = 0; pls[i] = 0;
            end
        end else begin
            tgt_now = tgt(m_mode, cur.sm, cur.sd);
            vs_rise = cur.vs && !m_vs_d;
            if (!cur.sm && (pls[0] != pls[1])) begin
                if (pls[0]) m_mode = (m_mode + 1) % (NF + 1);
                else        m_mode = (m_mode + NF) % (NF + 1);
            end
            lvl[0] = cur.bn;
            lvl[1] = cur.bp;
            // A level is accepted after DB consecutive synchronised samples differ from it.
            for (int i = 0; i < 2; i++) begin
                pls[i] = 0;
                if (lvl[i] == st[i]) run[i] = 0;
                else begin
                    run[i]++;
                    if (run[i] == DB) begin
                        st[i]  = lvl[i];
                        run[i] = 0;
                        pls[i] = lvl[i] && arm[i];
                    end
                end
                if (!lvl[i]) arm[i] = 1;
            end
            tgt_aft = tgt(m_mode, nxt.sm, nxt.sd);
`ifdef FRAME_SYNC_EN
            if (m_pend && vs_rise) begin
                m_en   = tgt_now;
                m_pend = (tgt_aft != tgt_now);
            end else begin
                m_pend = (tgt_now != m_en);
            end
`else
            m_en   = tgt_now;
            m_pend = 0;
`endif
        end
        m_vs_d  = cur.vs;
        hist[1] = hist[0];
        hist[0] = now;
    endtask

    initial begin
        hist[0] = '0;
        hist[1] = '0;
        forever begin
            @(posedge clk);
            model_step();
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (m_valid) begin
                chk("model_en_out", 32'(en_out), 32'(m_en));
                chk("model_mode_idx", 32'(mode_idx), 32'(m_mode));
                chk("model_pending", 32'(pending), 32'(m_pend));
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input logic bn, input logic bp);
        btn_next = bn;
        btn_prev = bp;
        tick(10);
        btn_next = 1'b0;
        btn_prev = 1'b0;
        tick(10);
    endtask

    task automatic frame();
        vsync = 1'b1;
        tick(3);
        vsync = 1'b0;
        tick(3);
    endtask

    task automatic chk_state(input string name, input logic [7:0] en, input int mode,
                             input logic pend);
        chk({name, "_en"}, 32'(en_out), 32'(en));
        chk({name, "_mode"}, 32'(mode_idx), 32'(mode));
        chk({name, "_pend"}, 32'(pending), 32'(pend));
    endtask

`ifdef FRAME_SYNC_EN
    localparam bit FS = 1'b1;
`else
    localparam bit FS = 1'b0;
`endif

    initial begin
        rst = 1'b1; btn_next = 1'b1; btn_prev = 1'b0;
        sw_mode = 1'b0; sw_direct = '0; vsync = 1'b0;
        tick(5);
        chk_state("reset", 8'h00, 0, 1'b0);
        rst = 1'b0;
        tick(15);
        chk("held_through_reset", 32'(mode_idx), 32'd0);
        btn_next = 1'b0;
        tick(10);
        chk("after_release", 32'(mode_idx), 32'd0);

        press(1'b1, 1'b0);
        chk_state("first_next", FS ? 8'h00 : 8'h01, 1, FS);
        frame();
        chk_state("first_commit", 8'h01, 1, 1'b0);

        for (int k = 2; k <= 9; k++) begin
            press(1'b1, 1'b0);
            chk("next_seq", 32'(mode_idx), 32'(k % 9));
        end
        press(1'b0, 1'b1);
        chk("prev_wrap", 32'(mode_idx), 32'd8);
        frame();
        chk_state("prev_commit", 8'h80, 8, 1'b0);

        btn_next = 1'b1;
        tick(2);
        btn_next = 1'b0;
        tick(10);
        chk("glitch", 32'(mode_idx), 32'd8);
        press(1'b1, 1'b1);
        chk_state("both_buttons", 8'h80, 8, 1'b0);

        sw_mode = 1'b1;
        sw_direct = 8'hA5;
        tick(6);
        chk_state("direct_wait", FS ? 8'h80 : 8'hA5, 8, FS);
        frame();
        chk_state("direct_commit", 8'hA5, 8, 1'b0);
        sw_mode = 1'b0;
        tick(6);
        chk_state("cycle_wait", FS ? 8'hA5 : 8'h80, 8, FS);
        frame();
        chk_state("cycle_commit", 8'h80, 8, 1'b0);

        for (int k = 0; k < 3; k++) press(1'b1, 1'b0);
        frame();
        chk_state("mode2_commit", 8'h02, 2, 1'b0);

        btn_next = 1'b1;
        tick(4);
        vsync = 1'b1;
        tick(3);
        vsync = 1'b0;
        tick(3);
        btn_next = 1'b0;
        tick(10);
        chk_state("same_cycle", FS ? 8'h02 : 8'h04, 3, FS);
        frame();
        chk_state("same_cycle_next", 8'h04, 3, 1'b0);

        press(1'b1, 1'b0);
        chk_state("undo_next", FS ? 8'h04 : 8'h08, 4, FS);
        press(1'b0, 1'b1);
        chk_state("undo_prev", 8'h04, 3, 1'b0);

        for (int s = 0; s < 150; s++) begin
            if ($urandom_range(0, 39) == 0) begin
                rst = 1'b1;
                tick(1);
                rst = 1'b0;
            end
            btn_next  = ($urandom_range(0, 2) == 0);
            btn_prev  = ($urandom_range(0, 3) == 0);
            sw_mode   = ($urandom_range(0, 4) == 0);
            sw_direct = 8'($urandom);
            vsync     = ($urandom_range(0, 1) == 1);
            tick($urandom_range(1, 12));
        end
        btn_next = 1'b0; btn_prev = 1'b0; vsync = 1'b0;
        tick(10);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
